sqrt_formula_scheduler: RTL and testbench
=========================================

Name: sqrt_formula_scheduler

Overview:
- Stall-capable task scheduler that shares a small pool of FSM-based formula units (formula_1_impl_1_top / formula_1_impl_2_top / formula_2_top, instantiated outside this block) among an incoming stream of (a, b, c) triples.
- Dispatches each accepted triple to the next unit in strict round-robin order and retires results in the same order, so output order equals input order.
- Applies backpressure via arg_rdy when the next unit is still busy.
- Sits between the argument source and the unit pool; replaces the one-unit-per-in-flight-task distributor with N_UNITS = 3..8 units.

Parameters:
- N_UNITS, 4, number of attached formula units (2..16).
- W, 32, argument and result width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- arg_vld  in  1  input triple valid
- arg_rdy  out  1  scheduler can accept a triple this cycle
- a  in  W  argument a
- b  in  W  argument b
- c  in  W  argument c
- unit_arg_vld  out  N_UNITS  one-hot start pulse per unit
- unit_a  out  W  registered a, broadcast to all units
- unit_b  out  W  registered b, broadcast to all units
- unit_c  out  W  registered c, broadcast to all units
- unit_res_vld  in  N_UNITS  per-unit result pulse
- unit_res  in  N_UNITS*W  per-unit results; unit i occupies bits [i*W +: W]
- res_vld  out  1  in-order result valid (single-cycle pulse)
- res  out  W  result
- in_flight  out  $clog2(N_UNITS+1)  number of busy units
- err  out  1  sticky protocol error

Behaviour:
- State per unit i: busy[i], done[i], hold[i] (W bits). Pointers disp_ptr and ret_ptr, each in 0..N_UNITS-1, wrapping N_UNITS-1 -> 0.
- Reset (rst == 0 at posedge): busy, done, pointers, unit_arg_vld, res_vld, err, in_flight, unit_a/b/c and res all return to 0.
  - Reset mid-operation discards every in-flight task. The units share rst.
- arg_rdy = ~busy[disp_ptr]. It is combinational from registers only and never depends on arg_vld.
- Accept in cycle t (arg_vld & arg_rdy):
  - Edge at end of t: busy[disp_ptr] <= 1; unit_a/b/c <= a/b/c; disp_ptr advances.
  - unit_arg_vld[old disp_ptr] is high for exactly cycle t+1; all other unit_arg_vld bits are 0.
  - unit_a/b/c hold their value until the next accept.
- arg_vld with arg_rdy == 0: nothing happens. The source holds the triple; no drop, no reorder.
- Capture: unit_res_vld[i] in cycle t with busy[i] == 1 and done[i] == 0 sets hold[i] <= unit_res slice i and done[i] <= 1.
  - unit_res_vld[i] with busy[i] == 0 or done[i] == 1 is ignored and sets err <= 1.
  - err is cleared only by reset.
- Retire: if done[ret_ptr] == 1 in cycle t:
  - res <= hold[ret_ptr]; res_vld <= 1 for cycle t+1.
  - busy[ret_ptr] and done[ret_ptr] are cleared; ret_ptr advances.
  - At most one retire per cycle. Otherwise res_vld <= 0 and res holds its last value.
- Results arriving out of order across units wait in hold until ret_ptr reaches them.
- Latency: with unit latency L (unit_res_vld L cycles after unit_arg_vld), accept in cycle 0 gives res_vld in cycle L+3 when no older task is pending.
- A unit is busy for L+2 cycles; its earliest reuse is an accept in cycle L+3. Full rate (one triple per cycle) is sustained iff N_UNITS >= L+3; otherwise arg_rdy deasserts periodically.
- Simultaneous events:
  - Retire and accept on the same unit in the same cycle: not possible; arg_rdy uses registered busy, so the freed unit is acceptable the next cycle.
  - Capture on unit i and retire of unit j != i in the same cycle: both happen.
  - Capture and retire of the same unit cannot coincide, because done is registered.
- in_flight = popcount(busy), registered; it updates the cycle after an accept or retire, and is unchanged when both happen in the same cycle.
- Empty: all busy = 0, in_flight = 0, arg_rdy = 1. Full: in_flight = N_UNITS, arg_rdy = 0.

Test Plan:
- Bench units: behavioural models with per-unit programmable latency, result = a+b+c.
- Single task: reset, a=1 b=2 c=3 in cycle 0, L=10 -> unit_arg_vld = 4'b0001 in cycle 1; res_vld in cycle 13 with res=6; in_flight goes 0 -> 1 -> 0.
- Full rate, N_UNITS=4, L=1: 40 back-to-back triples (a=k, b=0, c=0) -> arg_rdy never drops; 40 res_vld pulses; res = 0..39 in order.
- Stall, N_UNITS=4, L=10: continuous arg_vld -> 4 accepts, then arg_rdy=0 until unit 0 retires (cycle 13); no triple lost or duplicated; results in order.
- Reordering: unit latencies 20/5/5/5, four triples k=1..4 -> units 1..3 finish first, but res order is 1, 2, 3, 4, with res_vld pulses in 4 consecutive cycles after unit 0 completes.
- Protocol error: inject unit_res_vld[2] while idle -> err=1 and stays 1; no res_vld; in_flight unchanged.
- Reset mid-run: rst=0 for 1 cycle with 3 tasks in flight -> next cycle in_flight=0, arg_rdy=1, res_vld=0, pointers at 0; a new triple is dispatched to unit 0.

Source files
------------

// File: rtl/sqrt_formula_scheduler_if.sv
// Bundle between the argument source, the formula-unit pool and the result sink.
//   slave  : scheduler view (accepts triples, drives units, emits ordered results)
//   master : environment view (argument source, unit pool, result sink)
// Signals:
//   arg_vld/arg_rdy, a/b/c       : incoming triple handshake
//   unit_arg_vld, unit_a/b/c     : one-hot start pulse and broadcast arguments
//   unit_res_vld, unit_res       : per-unit result pulse, unit i at [i*W +: W]
//   res_vld, res                 : in-order result pulse
//   in_flight, err               : busy-unit count, sticky protocol error
interface sqrt_formula_scheduler_if #(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned W       = 32
);
  localparam int unsigned CntW = $clog2(N_UNITS + 1);

  logic                 arg_vld;
  logic                 arg_rdy;
  logic [W-1:0]         a;
  logic [W-1:0]         b;
  logic [W-1:0]         c;
  logic [N_UNITS-1:0]   unit_arg_vld;
  logic [W-1:0]         unit_a;
  logic [W-1:0]         unit_b;
  logic [W-1:0]         unit_c;
  logic [N_UNITS-1:0]   unit_res_vld;
  logic [N_UNITS*W-1:0] unit_res;
  logic                 res_vld;
  logic [W-1:0]         res;
  logic [CntW-1:0]      in_flight;
  logic                 err;

  modport slave (
    input  arg_vld, a, b, c, unit_res_vld, unit_res,
    output arg_rdy, unit_arg_vld, unit_a, unit_b, unit_c, res_vld, res, in_flight, err
  );

  modport master (
    output arg_vld, a, b, c, unit_res_vld, unit_res,
    input  arg_rdy, unit_arg_vld, unit_a, unit_b, unit_c, res_vld, res, in_flight, err
  );
endinterface

// File: rtl/sqrt_formula_scheduler.sv
// Round-robin scheduler sharing N_UNITS formula units among a stream of (a, b, c)
// triples. Triples are dispatched to units in strict rotation and results are
// retired in the same rotation, so output order equals input order.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-low
//   bus  : sqrt_formula_scheduler_if.slave (argument, unit and result signals)
module sqrt_formula_scheduler #(
  parameter int unsigned N_UNITS = 4,
  parameter int unsigned W       = 32
) (
  input logic                  clk,
  input logic                  rst,
  sqrt_formula_scheduler_if.slave bus
);

  localparam int unsigned PtrW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int unsigned CntW = $clog2(N_UNITS + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(N_UNITS - 1);

  logic [N_UNITS-1:0] busy_q, busy_d;
  logic [N_UNITS-1:0] done_q, done_d;
  logic [W-1:0]       hold_q [N_UNITS];
  logic [W-1:0]       hold_d [N_UNITS];
  logic [PtrW-1:0]    disp_ptr_q, disp_ptr_d;
  logic [PtrW-1:0]    ret_ptr_q, ret_ptr_d;
  logic [N_UNITS-1:0] unit_arg_vld_q, unit_arg_vld_d;
  logic [W-1:0]       unit_a_q, unit_a_d;
  logic [W-1:0]       unit_b_q, unit_b_d;
  logic [W-1:0]       unit_c_q, unit_c_d;
  logic               res_vld_q, res_vld_d;
  logic [W-1:0]       res_q, res_d;
  logic [CntW-1:0]    in_flight_q, in_flight_d;
  logic               err_q, err_d;

  logic arg_rdy;
  logic accept;
  logic retire;

  // Readiness depends on registered state only, never on arg_vld.
  assign arg_rdy = ~busy_q[disp_ptr_q];
  assign accept  = bus.arg_vld & arg_rdy;
  // done implies busy, so a retiring unit is never the one being accepted.
  assign retire  = done_q[ret_ptr_q];

  always_comb begin
    busy_d         = busy_q;
    done_d         = done_q;
    hold_d         = hold_q;
    disp_ptr_d     = disp_ptr_q;
    ret_ptr_d      = ret_ptr_q;
    unit_arg_vld_d = '0;
    unit_a_d       = unit_a_q;
    unit_b_d       = unit_b_q;
    unit_c_d       = unit_c_q;
    res_vld_d      = 1'b0;
    res_d          = res_q;
    err_d          = err_q;
    in_flight_d    = '0;

    // Capture: a result is only legal from a unit that is busy and not yet done.
    for (int i = 0; i < N_UNITS; i++) begin
      if (bus.unit_res_vld[i]) begin
        if (busy_q[i] && !done_q[i]) begin
          done_d[i] = 1'b1;
          hold_d[i] = bus.unit_res[i*W +: W];
        end else begin
          err_d = 1'b1;
        end
      end
    end

    if (accept) begin
      busy_d[disp_ptr_q]         = 1'b1;
      unit_arg_vld_d[disp_ptr_q] = 1'b1;
      unit_a_d                   = bus.a;
      unit_b_d                   = bus.b;
      unit_c_d                   = bus.c;
      disp_ptr_d = (disp_ptr_q == LastPtr) ? '0 : disp_ptr_q + PtrW'(1);
    end

    if (retire) begin
      busy_d[ret_ptr_q] = 1'b0;
      done_d[ret_ptr_q] = 1'b0;
      res_vld_d         = 1'b1;
      res_d             = hold_q[ret_ptr_q];
      ret_ptr_d = (ret_ptr_q == LastPtr) ? '0 : ret_ptr_q + PtrW'(1);
    end

    for (int i = 0; i < N_UNITS; i++) begin
      in_flight_d = in_flight_d + CntW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q         <= '0;
      done_q         <= '0;
      disp_ptr_q     <= '0;
      ret_ptr_q      <= '0;
      unit_arg_vld_q <= '0;
      unit_a_q       <= '0;
      unit_b_q       <= '0;
      unit_c_q       <= '0;
      res_vld_q      <= 1'b0;
      res_q          <= '0;
      in_flight_q    <= '0;
      err_q          <= 1'b0;
      for (int i = 0; i < N_UNITS; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      hold_q         <= hold_d;
      disp_ptr_q     <= disp_ptr_d;
      ret_ptr_q      <= ret_ptr_d;
      unit_arg_vld_q <= unit_arg_vld_d;
      unit_a_q       <= unit_a_d;
      unit_b_q       <= unit_b_d;
      unit_c_q       <= unit_c_d;
      res_vld_q      <= res_vld_d;
      res_q          <= res_d;
      in_flight_q    <= in_flight_d;
      err_q          <= err_d;
    end
  end

  assign bus.arg_rdy      = arg_rdy;
  assign bus.unit_arg_vld = unit_arg_vld_q;
  assign bus.unit_a       = unit_a_q;
  assign bus.unit_b       = unit_b_q;
  assign bus.unit_c       = unit_c_q;
  assign bus.res_vld      = res_vld_q;
  assign bus.res          = res_q;
  assign bus.in_flight    = in_flight_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_sqrt_formula_scheduler.sv
module tb_sqrt_formula_scheduler;
  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    int unsigned  lat;
    logic [W-1:0] exp_res;
    int           exp_latency;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  sqrt_formula_scheduler_if #(.N_UNITS(N), .W(W)) bus ();

  sqrt_formula_scheduler #(.N_UNITS(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural formula units: result = a+b+c, unit_res_vld lat cycles after start.
  int unsigned  lat  [N];
  int unsigned  cnt  [N];
  logic [W-1:0] msum [N];
  logic [N-1:0] mvld;
  logic [N-1:0] inj;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        cnt[i]  <= 0;
        mvld[i] <= 1'b0;
      end else begin
        mvld[i] <= 1'b0;
        if (bus.unit_arg_vld[i]) begin
          msum[i] <= bus.unit_a + bus.unit_b + bus.unit_c;
          if (lat[i] == 1) mvld[i] <= 1'b1;
          else cnt[i] <= lat[i] - 1;
        end else if (cnt[i] == 1) begin
          mvld[i] <= 1'b1;
          cnt[i]  <= 0;
        end else if (cnt[i] > 1) begin
          cnt[i] <= cnt[i] - 1;
        end
      end
    end
  end

  assign bus.unit_res_vld = mvld | inj;
  always_comb begin
    for (int i = 0; i < N; i++) bus.unit_res[i*W +: W] = msum[i];
  end

  // Result monitor.
  logic [W-1:0] res_q[$];
  int           res_cyc_q[$];
  always @(negedge clk) begin
    if (bus.res_vld === 1'b1) begin
      res_q.push_back(bus.res);
      res_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic set_lat(input int unsigned l0, l1, l2, l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  task automatic do_reset();
    bus.arg_vld = 1'b0;
    inj = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    res_q.delete();
    res_cyc_q.delete();
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [W-1:0] va, vb, vc, output int acc_cyc, output int stalls);
    logic r;
    int   cnow;
    bus.arg_vld = 1'b1;
    bus.a = va;
    bus.b = vb;
    bus.c = vc;
    stalls = 0;
    acc_cyc = -1;
    forever begin
      @(negedge clk);
      r = bus.arg_rdy;
      cnow = cyc;
      @(posedge clk);
      if (r) begin
        acc_cyc = cnow;
        break;
      end
      stalls++;
      if (stalls > 200) begin
        chk("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    #1;
  endtask

  task automatic wait_res(input int n, input int limit);
    int k = 0;
    while (res_q.size() < n && k < limit) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (res_q.size() < n) chk("wait_res_timeout", 64'(res_q.size()), 64'(n));
  endtask

  vec_t vecs[4];
  int   acc, st, acc0, acc_first, acc_last, tot_st;
  int   accs[8];
  int   stl[8];

  initial begin
    rst = 1'b0;
    bus.arg_vld = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c = '0;
    inj = '0;
    set_lat(1, 1, 1, 1);

    vecs[0] = '{a: 1,            b: 2,   c: 3,   lat: 10, exp_res: 6,   exp_latency: 13};
    vecs[1] = '{a: 32'hFFFFFFFF, b: 1,   c: 0,   lat: 1,  exp_res: 0,   exp_latency: 4};
    vecs[2] = '{a: 100,          b: 200, c: 300, lat: 3,  exp_res: 600, exp_latency: 6};
    vecs[3] = '{a: 7,            b: 8,   c: 9,   lat: 5,  exp_res: 24,  exp_latency: 8};

    // Reset state.
    do_reset();
    chk("rst_in_flight", 64'(bus.in_flight), 64'd0);
    chk("rst_arg_rdy", 64'(bus.arg_rdy), 64'd1);
    chk("rst_res_vld", 64'(bus.res_vld), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    chk("rst_unit_arg_vld", 64'(bus.unit_arg_vld), 64'd0);
    chk("rst_res", 64'(bus.res), 64'd0);

    // Single-task vectors.
    foreach (vecs[v]) begin
      do_reset();
      set_lat(vecs[v].lat, vecs[v].lat, vecs[v].lat, vecs[v].lat);
      send(vecs[v].a, vecs[v].b, vecs[v].c, acc, st);
      chk("single_stall", 64'(st), 64'd0);
      chk("single_start_onehot", 64'(bus.unit_arg_vld), 64'b0001);
      chk("single_unit_a", 64'(bus.unit_a), 64'(vecs[v].a));
      chk("single_in_flight_1", 64'(bus.in_flight), 64'd1);
      bus.arg_vld = 1'b0;
      @(posedge clk);
      #1 chk("single_start_pulse_end", 64'(bus.unit_arg_vld), 64'd0);
      wait_res(1, 60);
      if (res_q.size() >= 1) begin
        chk("single_res", 64'(res_q[0]), 64'(vecs[v].exp_res));
        chk("single_latency", 64'(res_cyc_q[0] - acc), 64'(vecs[v].exp_latency));
      end
      chk("single_res_vld_pulse", 64'(bus.res_vld), 64'd0);
      chk("single_in_flight_0", 64'(bus.in_flight), 64'd0);
    end

    // Full rate: L=1, 40 back-to-back triples.
    do_reset();
    set_lat(1, 1, 1, 1);
    tot_st = 0;
    acc_first = 0;
    acc_last = 0;
    for (int k = 0; k < 40; k++) begin
      send(W'(k), 0, 0, acc, st);
      tot_st += st;
      if (k == 0) acc_first = acc;
      acc_last = acc;
    end
    bus.arg_vld = 1'b0;
    chk("full_rate_stalls", 64'(tot_st), 64'd0);
    chk("full_rate_span", 64'(acc_last - acc_first), 64'd39);
    wait_res(40, 100);
    chk("full_rate_count", 64'(res_q.size()), 64'd40);
    for (int k = 0; k < 40 && k < res_q.size(); k++) chk("full_rate_res", 64'(res_q[k]), 64'(k));
    if (res_q.size() >= 40) chk("full_rate_res_span", 64'(res_cyc_q[39] - res_cyc_q[0]), 64'd39);

    // Stall: L=10, continuous valid for 8 triples.
    do_reset();
    set_lat(10, 10, 10, 10);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        chk("stall_full_in_flight", 64'(bus.in_flight), 64'd4);
        chk("stall_full_arg_rdy", 64'(bus.arg_rdy), 64'd0);
      end
      send(W'(k + 100), W'(k + 100), 0, accs[k], stl[k]);
    end
    bus.arg_vld = 1'b0;
    chk("stall_first4", 64'(accs[3] - accs[0]), 64'd3);
    chk("stall_reuse_cycle", 64'(accs[4] - accs[0]), 64'd13);
    chk("stall_wait_cycles", 64'(stl[4]), 64'd9);
    chk("stall_next3", 64'(accs[7] - accs[4]), 64'd3);
    wait_res(8, 100);
    repeat (5) @(posedge clk);
    #1 chk("stall_count", 64'(res_q.size()), 64'd8);
    for (int k = 0; k < 8 && k < res_q.size(); k++) chk("stall_res", 64'(res_q[k]), 64'(2 * (k + 100)));

    // Reordering: unit 0 slow, units 1..3 fast.
    do_reset();
    set_lat(20, 5, 5, 5);
    acc0 = 0;
    for (int k = 1; k <= 4; k++) begin
      send(W'(k), 0, 0, acc, st);
      if (k == 1) acc0 = acc;
    end
    bus.arg_vld = 1'b0;
    wait_res(4, 100);
    for (int k = 0; k < 4 && k < res_q.size(); k++) begin
      chk("reorder_res", 64'(res_q[k]), 64'(k + 1));
      chk("reorder_cycle", 64'(res_cyc_q[k] - acc0), 64'(23 + k));
    end

    // Protocol error while idle.
    do_reset();
    chk("err_clear", 64'(bus.err), 64'd0);
    inj = 4'b0100;
    @(posedge clk);
    #1 inj = '0;
    chk("err_set", 64'(bus.err), 64'd1);
    chk("err_in_flight", 64'(bus.in_flight), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("err_sticky", 64'(bus.err), 64'd1);
    chk("err_no_res", 64'(res_q.size()), 64'd0);
    chk("err_arg_rdy", 64'(bus.arg_rdy), 64'd1);

    // Reset with three tasks in flight.
    do_reset();
    set_lat(10, 10, 10, 10);
    for (int k = 0; k < 3; k++) send(W'(k + 50), 0, 0, acc, st);
    bus.arg_vld = 1'b0;
    chk("mid_in_flight_3", 64'(bus.in_flight), 64'd3);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("mid_rst_in_flight", 64'(bus.in_flight), 64'd0);
    chk("mid_rst_arg_rdy", 64'(bus.arg_rdy), 64'd1);
    chk("mid_rst_res_vld", 64'(bus.res_vld), 64'd0);
    chk("mid_rst_unit_arg_vld", 64'(bus.unit_arg_vld), 64'd0);
    res_q.delete();
    res_cyc_q.delete();
    send(5, 5, 5, acc, st);
    bus.arg_vld = 1'b0;
    chk("mid_redispatch_unit0", 64'(bus.unit_arg_vld), 64'b0001);
    wait_res(1, 60);
    if (res_q.size() >= 1) chk("mid_res", 64'(res_q[0]), 64'd15);
    repeat (20) @(posedge clk);
    #1 chk("mid_no_stale", 64'(res_q.size()), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
